ysyx_25060170_fetch_ctrl: RTL

YSYX_25060170_FETCH_CTRL -- requirements
Module: ysyx_25060170_fetch_ctrl

---
 rtl/ysyx_25060170_fetch_ctrl.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/ysyx_25060170_fetch_ctrl.sv
// Instruction fetch controller: issues one read at a time to instruction
// memory, hands the returned word to decode and follows execute redirects.
//
// Handshakes: every channel (AR, R, inst) transfers on a rising edge where
// valid and ready are both high. A source never drops valid and never
// changes its payload while valid is high and ready is low.
module ysyx_25060170_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_en,
  input  logic [31:0] jump_addr,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] inst,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] pc,
  output logic        fetch_err,
  output logic [31:0] fetch_cnt,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    OUT  = 3'd3,
    HALT = 3'd4
  } state_t;

  state_t      state;
  logic        redirect_pending;
  logic [31:0] redirect_addr;
  logic [31:0] redirect_tgt;
  logic        redirect_any;
  logic [31:0] out_tgt;

  // A same-cycle jump_en is newer than anything stored, so it wins.
  assign redirect_tgt = jump_en ? jump_addr : redirect_addr;
  assign redirect_any = jump_en | redirect_pending;
  // Next pc after a delivered instruction; 32-bit add wraps naturally.
  assign out_tgt      = jump_en ? jump_addr : (pc + 32'd4);

  // The read address is always the pc register, so it cannot move while
  // arvalid is high (pc only changes outside REQ).
  assign araddr    = pc;
  assign dbg_state = state;

  // Fetch FSM with all handshake outputs registered alongside the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= IDLE;
      pc               <= RESET_PC;
      arvalid          <= 1'b0;
      rready           <= 1'b0;
      inst_valid       <= 1'b0;
      inst             <= 32'd0;
      fetch_err        <= 1'b0;
      fetch_cnt        <= 32'd0;
      redirect_pending <= 1'b0;
      redirect_addr    <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          state   <= REQ;
          arvalid <= 1'b1;
          if (redirect_any) begin
            pc               <= redirect_tgt;
            redirect_pending <= 1'b0;
            if (redirect_tgt[1:0] != 2'b00) begin
              state     <= HALT;
              arvalid   <= 1'b0;
              fetch_err <= 1'b1;
            end
          end
        end

        REQ: begin
          // The outstanding request is never withdrawn; a redirect waits.
          if (jump_en) begin
            redirect_pending <= 1'b1;
            redirect_addr    <= jump_addr;
          end
          if (arready) begin
            state   <= WAIT;
            arvalid <= 1'b0;
            rready  <= 1'b1;
          end
        end

        WAIT: begin
          if (rvalid) begin
            rready <= 1'b0;
            if (rresp != 2'b00) begin
              state     <= HALT;
              fetch_err <= 1'b1;
            end else if (redirect_any) begin
              // Stale response for the old path: drop it and refetch.
              pc               <= redirect_tgt;
              redirect_pending <= 1'b0;
              if (redirect_tgt[1:0] != 2'b00) begin
                state     <= HALT;
                fetch_err <= 1'b1;
              end else begin
                state   <= REQ;
                arvalid <= 1'b1;
              end
            end else begin
              inst       <= rdata;
              inst_valid <= 1'b1;
              state      <= OUT;
            end
          end else if (jump_en) begin
            redirect_pending <= 1'b1;
            redirect_addr    <= jump_addr;
          end
        end

        OUT: begin
          // jump_en only matters on the cycle decode takes the instruction.
          if (inst_ready) begin
            inst_valid       <= 1'b0;
            pc               <= out_tgt;
            fetch_cnt        <= fetch_cnt + 32'd1;
            redirect_pending <= 1'b0;
            if (out_tgt[1:0] != 2'b00) begin
              state     <= HALT;
              fetch_err <= 1'b1;
            end else begin
              state   <= REQ;
              arvalid <= 1'b1;
            end
          end
        end

        HALT: begin
          state <= HALT;
        end

        default: begin
          state      <= HALT;
          arvalid    <= 1'b0;
          rready     <= 1'b0;
          inst_valid <= 1'b0;
          fetch_err  <= 1'b1;
        end
      endcase
    end
  end

endmodule
